if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 16, datapath/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, first fetch address.
REQ-003 SHALL have parameter INT_VECTOR, default 16'h0010, interrupt entry address.
REQ-004 SHALL have port: clk  in  1  rising-edge clock (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: stall  in  1  hazard hold request from ID/EX.
REQ-007 SHALL have port: flush  in  1  branch taken, redirect to branch_target.
REQ-008 SHALL have port: branch_target  in  CPU_WIDTH  redirect address.
REQ-009 SHALL have port: int_req  in  1  level interrupt request.
REQ-010 SHALL have port: reti  in  1  one-cycle return-from-interrupt pulse.
REQ-011 SHALL have port: imem_addr  out  CPU_WIDTH  instruction memory address (combinational read).
REQ-012 SHALL have port: imem_data  in  CPU_WIDTH  instruction word at imem_addr, same cycle.
REQ-013 SHALL have port: inst_id  out  CPU_WIDTH  IF/ID instruction to decode.
REQ-014 SHALL have port: pc_id  out  CPU_WIDTH  address of inst_id.
REQ-015 SHALL have port: valid_id  out  1  inst_id is a real instruction (0 = bubble).
REQ-016 SHALL have port: int_ack  out  1  one-cycle pulse on interrupt acceptance.
REQ-017 SHALL have port: epc  out  CPU_WIDTH  saved resume address.

Function
REQ-018 SHALL drive imem_addr = pc register, word-addressed; sequential next pc = pc+1, wrapping 16'hFFFF -> 16'h0000.
REQ-019 SHALL implement FSM states RUN and ISR; interrupts accepted only in RUN.
REQ-020 SHALL resolve per-cycle priority: reti (ISR only) > interrupt accept > flush > stall > sequential.
REQ-021 Sequential: pc <= pc+1; inst_id <= imem_data, pc_id <= pc, valid_id <= 1.
REQ-022 Stall (no higher event): pc, inst_id, pc_id, valid_id SHALL hold.
REQ-023 Flush: pc <= branch_target; valid_id <= 0, inst_id <= NOP (16'h0000); overrides stall.
REQ-024 Interrupt accept when state=RUN, int_req=1, stall=0: epc <= (flush ? branch_target : pc); pc <= INT_VECTOR; bubble IF/ID; int_ack=1 next cycle only; state <= ISR.
REQ-025 int_req with stall=1 SHALL be deferred, not lost, while int_req stays high.
REQ-026 reti in ISR: pc <= epc; bubble IF/ID; state <= RUN; overrides flush and stall.
REQ-027 reti in RUN SHALL be ignored; int_req in ISR SHALL be ignored (no nesting).
REQ-028 int_ack SHALL be registered, high exactly one cycle per accepted interrupt.
REQ-029 Fetch-to-ID latency SHALL be one cycle: word at imem_addr in cycle n appears on inst_id in cycle n+1.

Reset
REQ-030 On rst_n=0, immediately: pc=RESET_PC, inst_id=16'h0000, pc_id=0, valid_id=0, epc=0, int_ack=0, state=RUN.
REQ-031 Reset mid-operation (including in ISR) SHALL discard all pending redirects and interrupt state.
REQ-032 First cycle after reset release SHALL present imem_addr=RESET_PC.

Structure
REQ-033 RESET_PC, INT_VECTOR, NOP encoding and FSM state encodings SHALL live in the shared para.v include.
REQ-034 The IF/ID pipeline register (inst_id, pc_id, valid_id with hold/bubble controls) SHALL be one sub-module, if_id_reg.

Verification
REQ-035 Reset release, ROM[0..3]=A,B,C,D, no events -> inst_id A,B,C,D on cycles 1..4, pc_id 0..3, valid_id 1.
REQ-036 stall high 2 cycles at pc=2 -> imem_addr stays 2, inst_id/pc_id held (B/1) both cycles, then resumes with C.
REQ-037 flush with branch_target=16'h0040 at pc=5, stall=1 same cycle -> next imem_addr=16'h0040, valid_id=0 one cycle.
REQ-038 int_req at pc=7, stall=0 -> epc=7, imem_addr=16'h0010, int_ack one-cycle pulse, valid_id=0; later reti -> imem_addr=7, state RUN.
REQ-039 int_req during ISR and reti+flush same cycle -> no second int_ack; pc <= epc, flush ignored.
REQ-040 pc=16'hFFFF sequential -> next imem_addr=16'h0000; rst_n low mid-ISR -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
// Reset/interrupt addresses, NOP encoding and fetch-state enum live here.
package if_stage_pkg;

    localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
    localparam logic [15:0] INT_VECTOR_DEF = 16'h0010;
    localparam logic [15:0] NOP_INST       = 16'h0000;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched word and its address,
// with a bubble control (insert NOP, valid=0) that wins over hold.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_hold,
    input  logic         i_bubble,
    input  logic [W-1:0] i_inst,
    input  logic [W-1:0] i_pc,
    output logic [W-1:0] o_inst,
    output logic [W-1:0] o_pc,
    output logic         o_valid
);

    localparam logic [W-1:0] NOP_W = W'(NOP_INST);

    logic [W-1:0] r_inst;
    logic [W-1:0] r_pc;
    logic         r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst  <= NOP_W;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            // pc_id still tracks the discarded fetch address for debug visibility
            r_inst  <= NOP_W;
            r_pc    <= i_pc;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing with stall, branch redirect,
// single-level interrupt entry/return, feeding the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                   CPU_WIDTH  = 16,
    parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(RESET_PC_DEF),
    parameter logic [CPU_WIDTH-1:0] INT_VECTOR = CPU_WIDTH'(INT_VECTOR_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [CPU_WIDTH-1:0] branch_target,
    input  logic                 int_req,
    input  logic                 reti,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic [CPU_WIDTH-1:0] imem_data,
    output logic [CPU_WIDTH-1:0] inst_id,
    output logic [CPU_WIDTH-1:0] pc_id,
    output logic                 valid_id,
    output logic                 int_ack,
    output logic [CPU_WIDTH-1:0] epc
);

    localparam logic [CPU_WIDTH-1:0] PC_ONE = {{(CPU_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;
    logic [CPU_WIDTH-1:0] r_pc;
    logic [CPU_WIDTH-1:0] w_pc_next;
    logic [CPU_WIDTH-1:0] r_epc;
    logic [CPU_WIDTH-1:0] w_epc_next;
    logic                 r_int_ack;
    logic                 w_reti_take;
    logic                 w_int_take;
    logic                 w_bubble;
    logic                 w_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_epc     <= '0;
            r_int_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_epc     <= w_epc_next;
            r_int_ack <= w_int_take;
        end
    end

    // Event priority: reti (ISR only) > interrupt accept > flush > stall > sequential
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc + PC_ONE;
        w_epc_next   = r_epc;
        w_reti_take  = 1'b0;
        w_int_take   = 1'b0;
        w_bubble     = 1'b0;
        w_hold       = 1'b0;

        case (r_state)
            ST_ISR: begin
                if (reti) begin
                    w_reti_take  = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                if (int_req && !stall) begin
                    w_int_take   = 1'b1;
                    w_state_next = ST_ISR;
                end
            end
        endcase

        if (w_reti_take) begin
            w_pc_next = r_epc;
            w_bubble  = 1'b1;
        end else if (w_int_take) begin
            // A same-cycle branch means the branch target is the resume point
            w_epc_next = flush ? branch_target : r_pc;
            w_pc_next  = INT_VECTOR;
            w_bubble   = 1'b1;
        end else if (flush) begin
            w_pc_next = branch_target;
            w_bubble  = 1'b1;
        end else if (stall) begin
            w_pc_next = r_pc;
            w_hold    = 1'b1;
        end
    end

    if_id_reg #(
        .W (CPU_WIDTH)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hold   (w_hold),
        .i_bubble (w_bubble),
        .i_inst   (imem_data),
        .i_pc     (r_pc),
        .o_inst   (inst_id),
        .o_pc     (pc_id),
        .o_valid  (valid_id)
    );

    assign imem_addr = r_pc;
    assign int_ack   = r_int_ack;
    assign epc       = r_epc;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal
// expectations plus randomized traffic against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        int_req = 1'b0;
    logic        reti = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] inst_id;
    logic [15:0] pc_id;
    logic        valid_id;
    logic        int_ack;
    logic [15:0] epc;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the architectural fetch state
    logic [15:0] m_pc, m_inst, m_pcid, m_epc;
    logic        m_valid, m_ack, m_isr;
    bit          cmp_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return {~a[7:0], a[7:0]};
    endfunction

    assign imem_data = rom(imem_addr);

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .int_req       (int_req),
        .reti          (reti),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .inst_id       (inst_id),
        .pc_id         (pc_id),
        .valid_id      (valid_id),
        .int_ack       (int_ack),
        .epc           (epc)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_inst = 16'h0000; m_pcid = 16'h0000; m_epc = 16'h0000;
        m_valid = 1'b0; m_ack = 1'b0; m_isr = 1'b0;
    endtask

    // One clock of the fetch rules, applied to the inputs present at the edge
    task automatic model_step();
        logic [15:0] fetched;
        fetched = rom(m_pc);
        m_ack = 1'b0;
        if (m_isr && reti) begin
            m_isr = 1'b0;
            m_pcid = m_pc; m_inst = 16'h0000; m_valid = 1'b0;
            m_pc = m_epc;
        end else if (!m_isr && int_req && !stall) begin
            m_isr = 1'b1;
            m_ack = 1'b1;
            m_epc = flush ? branch_target : m_pc;
            m_pcid = m_pc; m_inst = 16'h0000; m_valid = 1'b0;
            m_pc = 16'h0010;
        end else if (flush) begin
            m_pcid = m_pc; m_inst = 16'h0000; m_valid = 1'b0;
            m_pc = branch_target;
        end else if (!stall) begin
            m_inst = fetched; m_pcid = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic drive(input bit s, input bit f, input logic [15:0] bt,
                         input bit ir, input bit rt);
        stall = s; flush = f; branch_target = bt; int_req = ir; reti = rt;
    endtask

    // Inputs already set; cross one rising edge and advance the model
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        cmp_en = 1'b0;
        #1;
        chk({tag, "_rst_addr"}, imem_addr, 16'h0000);
        chk({tag, "_rst_inst"}, inst_id, 16'h0000);
        chk({tag, "_rst_pcid"}, pc_id, 16'h0000);
        chk({tag, "_rst_valid"}, {15'd0, valid_id}, 16'h0000);
        chk({tag, "_rst_ack"}, {15'd0, int_ack}, 16'h0000);
        chk({tag, "_rst_epc"}, epc, 16'h0000);
        model_reset();
        drive(0, 0, 16'h0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk({tag, "_first_addr"}, imem_addr, 16'h0000);
    endtask

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("inst_id", inst_id, m_inst);
            chk("valid_id", {15'd0, valid_id}, {15'd0, m_valid});
            chk("int_ack", {15'd0, int_ack}, {15'd0, m_ack});
            chk("epc", epc, m_epc);
            if (m_valid) chk("pc_id", pc_id, m_pcid);
        end
    end

    initial begin
        model_reset();
        #23;
        chk("init_addr", imem_addr, 16'h0000);
        chk("init_valid", {15'd0, valid_id}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Straight-line fetch of A,B,C,D
        drive(0, 0, 16'h0, 0, 0);
        step(); chk("seq1_inst", inst_id, 16'hFF00); chk("seq1_pcid", pc_id, 16'h0000);
        step(); chk("seq2_inst", inst_id, 16'hFE01); chk("seq2_pcid", pc_id, 16'h0001);
        // Two-cycle stall at pc=2
        drive(1, 0, 16'h0, 0, 0);
        step(); chk("stall1_addr", imem_addr, 16'h0002); chk("stall1_inst", inst_id, 16'hFE01);
        step(); chk("stall2_addr", imem_addr, 16'h0002); chk("stall2_pcid", pc_id, 16'h0001);
        drive(0, 0, 16'h0, 0, 0);
        step(); chk("resume_inst", inst_id, 16'hFD02); chk("resume_valid", {15'd0, valid_id}, 16'h0001);
        step(); chk("seq4_inst", inst_id, 16'hFC03); chk("seq4_pcid", pc_id, 16'h0003);
        step(); chk("pc5", imem_addr, 16'h0005);
        // Flush overriding stall
        drive(1, 1, 16'h0040, 0, 0);
        step(); chk("flush_addr", imem_addr, 16'h0040); chk("flush_valid", {15'd0, valid_id}, 16'h0000);
        drive(0, 1, 16'h0007, 0, 0);
        step();
        // Interrupt accept at pc=7
        drive(0, 0, 16'h0, 1, 0);
        step(); chk("int_addr", imem_addr, 16'h0010); chk("int_epc", epc, 16'h0007);
        chk("int_ack1", {15'd0, int_ack}, 16'h0001); chk("int_valid", {15'd0, valid_id}, 16'h0000);
        step(); chk("int_ack_pulse", {15'd0, int_ack}, 16'h0000); chk("isr_seq", imem_addr, 16'h0011);
        // reti + flush + int_req in ISR: return to epc, flush and nesting ignored
        drive(0, 1, 16'h0099, 1, 1);
        step(); chk("reti_addr", imem_addr, 16'h0007); chk("reti_noack", {15'd0, int_ack}, 16'h0000);
        // Deferred interrupt under stall, then accepted
        drive(1, 0, 16'h0, 1, 0);
        step(); chk("defer_ack", {15'd0, int_ack}, 16'h0000);
        step(); chk("defer_addr", imem_addr, 16'h0007);
        drive(0, 0, 16'h0, 1, 0);
        step(); chk("defer_take", {15'd0, int_ack}, 16'h0001); chk("defer_epc", epc, 16'h0007);
        drive(0, 0, 16'h0, 0, 1);
        step(); chk("reti2_addr", imem_addr, 16'h0007);
        // Wrap at 16'hFFFF
        drive(0, 1, 16'hFFFF, 0, 0);
        step();
        drive(0, 0, 16'h0, 0, 0);
        step(); chk("wrap_addr", imem_addr, 16'h0000); chk("wrap_pcid", pc_id, 16'hFFFF);
        // Reset while in ISR
        drive(0, 0, 16'h0, 1, 0);
        step(); chk("isr_again", imem_addr, 16'h0010);
        drive(0, 0, 16'h0, 0, 0);
        step();
        async_reset_check("midisr");
        // Interrupt right after reset proves the ISR state was discarded
        drive(0, 0, 16'h0, 1, 0);
        step(); chk("post_rst_int", {15'd0, int_ack}, 16'h0001);
        drive(0, 0, 16'h0, 0, 1);
        step();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
                  16'($urandom), $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15);
            step();
            if (i == 1500) async_reset_check("rand");
        end

        drive(0, 0, 16'h0, 0, 0);
        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
